// File: rtl/link_order_queue.sv
// link_order_queue: host order FIFO that issues one order at a time to a table manager and returns its result.
// Optional LINK_ORDER_ERRCNT_EN adds err_count, a saturating count of failed non-read orders.
module link_order_queue #(
   parameter int ADDR_WIDTH  = 16,
   parameter int DATA_WIDTH  = 16,
   parameter int TABLE_WIDTH = 8,
   parameter int DEPTH_LOG2  = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_busy,
   input  logic [1:0]             in_type,
   input  logic [TABLE_WIDTH-1:0] in_table,
   input  logic [ADDR_WIDTH-1:0]  in_node,
   input  logic [DATA_WIDTH-1:0]  in_data,
   output logic                   order_valid,
   input  logic                   order_busy,
   output logic [1:0]             order_type,
   output logic [TABLE_WIDTH-1:0] order_table,
   output logic [ADDR_WIDTH-1:0]  order_node,
   output logic [DATA_WIDTH-1:0]  order_data,
   input  logic                   dout_valid,
   output logic                   dout_busy,
   input  logic [DATA_WIDTH-1:0]  dout_data,
   output logic                   resp_valid,
   input  logic                   resp_busy,
   output logic [1:0]             resp_type,
   output logic [DATA_WIDTH-1:0]  resp_data
`ifdef LINK_ORDER_ERRCNT_EN
   ,
   output logic [7:0]             err_count
`endif
);
   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int EW = 2 + TABLE_WIDTH + ADDR_WIDTH + DATA_WIDTH;
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
   state_t state, state_nx;
   logic [EW-1:0] mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wptr, rptr;
   logic [DEPTH_LOG2:0] count;
   logic push, pop, dxfer, rxfer;
   assign in_busy = count == (DEPTH_LOG2+1)'(DEPTH);
   assign push = in_valid && !in_busy;
   assign pop = order_valid && !order_busy;
   assign dxfer = dout_valid && !dout_busy;
   assign rxfer = resp_valid && !resp_busy;
   assign order_valid = state == ISSUE;
   assign dout_busy = state != WAIT;
   // head is stable during ISSUE: pushes never hit rptr's slot unless the FIFO is empty
   assign {order_type, order_table, order_node, order_data} = mem[rptr];
   always_ff @(posedge clk)
      if (push) mem[wptr] <= {in_type, in_table, in_node, in_data};
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = count != '0 ? ISSUE : IDLE;
         ISSUE:   state_nx = pop ? WAIT : ISSUE;
         WAIT:    state_nx = dxfer ? RESP : WAIT;
         default: state_nx = rxfer ? IDLE : RESP;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state      <= IDLE;
         wptr       <= '0;
         rptr       <= '0;
         count      <= '0;
         resp_valid <= 1'b0;
         resp_type  <= 2'b00;
         resp_data  <= '0;
      end else begin
         state <= state_nx;
         wptr  <= push ? wptr + 1'b1 : wptr;
         rptr  <= pop ? rptr + 1'b1 : rptr;
         count <= count + (DEPTH_LOG2+1)'(push) - (DEPTH_LOG2+1)'(pop);
         if (pop) resp_type <= order_type;
         if (dxfer) resp_data <= dout_data;
         resp_valid <= dxfer ? 1'b1 : rxfer ? 1'b0 : resp_valid;
      end
`ifdef LINK_ORDER_ERRCNT_EN
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) err_count <= 8'd0;
      else if (dxfer && resp_type != 2'b11 && dout_data == '0 && err_count != 8'hFF) err_count <= err_count + 8'd1;
`endif
endmodule

// File: tb/tb_link_order_queue.sv
// tb_link_order_queue: scoreboard bench for link_order_queue with a simple downstream manager model.
// Define LINK_ORDER_ERRCNT_EN for both files to also exercise err_count.
module tb_link_order_queue;
   localparam int AW = 16, DW = 16, TW = 8, DL = 2;
   typedef struct packed {logic [1:0] t; logic [TW-1:0] tb; logic [AW-1:0] n; logic [DW-1:0] d;} ord_t;
   logic clk = 1'b0, rst_n = 1'b0;
   logic in_valid, in_busy, order_valid, order_busy, dout_valid, dout_busy, resp_valid, resp_busy;
   logic [1:0] in_type, order_type, resp_type;
   logic [TW-1:0] in_table, order_table;
   logic [AW-1:0] in_node, order_node;
   logic [DW-1:0] in_data, order_data, dout_data, resp_data;
`ifdef LINK_ORDER_ERRCNT_EN
   logic [7:0] err_count;
`endif
   link_order_queue #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TABLE_WIDTH(TW), .DEPTH_LOG2(DL)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_busy(in_busy), .in_type(in_type), .in_table(in_table),
      .in_node(in_node), .in_data(in_data),
      .order_valid(order_valid), .order_busy(order_busy), .order_type(order_type),
      .order_table(order_table), .order_node(order_node), .order_data(order_data),
      .dout_valid(dout_valid), .dout_busy(dout_busy), .dout_data(dout_data),
      .resp_valid(resp_valid), .resp_busy(resp_busy), .resp_type(resp_type), .resp_data(resp_data)
`ifdef LINK_ORDER_ERRCNT_EN
      , .err_count(err_count)
`endif
   );
   always #5 clk = ~clk;
   int vectors = 0, miscompares = 0;
   ord_t exp_ord[$];
   logic [17:0] exp_resp[$];
   ord_t e;
   logic [17:0] r;
   int mcount;
   logic outstanding, push_acc = 1'b0, o_x = 1'b0, r_x = 1'b0, mgr_en = 1'b1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      o_x = rst_n && order_valid && !order_busy;
      r_x = rst_n && resp_valid && !resp_busy;
      if (o_x) begin
         check("issue_serial", outstanding, 0);
         if (exp_ord.size() == 0) check("order_unexpected", 1, 0);
         else begin
            e = exp_ord.pop_front();
            check("order_fields", {order_type, order_table, order_node, order_data}, e);
         end
      end
      if (r_x) begin
         if (exp_resp.size() == 0) check("resp_unexpected", 1, 0);
         else begin
            r = exp_resp.pop_front();
            check("resp_fields", {resp_type, resp_data}, r);
         end
      end
   end

   always @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         mcount <= 0;
         outstanding <= 1'b0;
      end else begin
         mcount <= mcount + int'(push_acc) - int'(o_x);
         outstanding <= o_x ? 1'b1 : r_x ? 1'b0 : outstanding;
      end

   // downstream manager: answers each accepted order with its data xor 0x00FF
   initial begin
      logic [DW-1:0] d;
      dout_valid = 1'b0;
      dout_data = '0;
      forever begin
         @(negedge clk);
         if (rst_n && mgr_en && order_valid && !order_busy) begin
            d = order_data ^ 16'h00FF;
            @(posedge clk); #1;
            dout_valid = 1'b1;
            dout_data = d;
            @(posedge clk); #1;
            dout_valid = 1'b0;
         end
      end
   end

   task automatic push(input logic [1:0] t, input logic [TW-1:0] tb, input logic [AW-1:0] n, input logic [DW-1:0] d);
      in_valid = 1'b1; in_type = t; in_table = tb; in_node = n; in_data = d;
      @(negedge clk);
      check("in_busy", in_busy, mcount == (1 << DL));
      if (mcount < (1 << DL)) begin
         exp_ord.push_back({t, tb, n, d});
         exp_resp.push_back({t, d ^ 16'h00FF});
         push_acc = 1'b1;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      push_acc = 1'b0;
   endtask

   task automatic drain(input string tag);
      int n = 0;
      while ((exp_ord.size() != 0 || exp_resp.size() != 0) && n < 300) begin
         @(posedge clk);
         n++;
      end
      #1;
      check(tag, n < 300, 1);
   endtask

   initial begin
      in_valid = 1'b0; in_type = '0; in_table = '0; in_node = '0; in_data = '0;
      order_busy = 1'b0; resp_busy = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_order_valid", order_valid, 0);
      check("rst_dout_busy", dout_busy, 1);
      check("rst_resp_valid", resp_valid, 0);
      check("rst_resp_type", resp_type, 0);
      check("rst_resp_data", resp_data, 0);
      check("rst_in_busy", in_busy, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      // read order latency and result path
      push(2'b11, 8'd3, 16'd2, 16'h0054);
      @(negedge clk);
      check("lat_cycle1", order_valid, 0);
      @(negedge clk);
      check("lat_cycle2", order_valid, 1);
      drain("drain_read");
      check("read_resp_data", resp_data, 16'h00AB);
      // three back-to-back orders issued in push order, one at a time
      push(2'b00, 8'd1, 16'h0100, 16'h1234);
      push(2'b01, 8'd2, 16'h0200, 16'h5678);
      push(2'b10, 8'd4, 16'h0300, 16'h9ABC);
      drain("drain_three");
      // fill the FIFO while the manager is busy; fifth push is dropped
      order_busy = 1'b1;
      for (int i = 0; i < 5; i++) push(2'(i), 8'(i + 10), 16'(i * 7), 16'(16'h4000 + i));
      repeat (3) begin
         @(negedge clk);
         check("full_hold", in_busy, 1);
      end
      @(posedge clk); #1;
      order_busy = 1'b0;
      drain("drain_full");
      // host stalls the response
      resp_busy = 1'b1;
      push(2'b11, 8'd5, 16'd9, 16'h0F0F);
      push(2'b00, 8'd6, 16'd8, 16'h3333);
      begin
         int n = 0;
         @(negedge clk);
         while (!resp_valid && n < 20) begin
            @(negedge clk);
            n++;
         end
         check("resp_arrive", resp_valid, 1);
      end
      repeat (10) begin
         check("stall_dout_busy", dout_busy, 1);
         check("stall_no_order", order_valid, 0);
         check("stall_resp_data", resp_data, 16'h0FF0);
         @(negedge clk);
      end
      @(posedge clk); #1;
      resp_busy = 1'b0;
      drain("drain_stall");
      // reset while WAITing with two orders queued
      mgr_en = 1'b0;
      push(2'b00, 8'd7, 16'd1, 16'h0001);
      push(2'b01, 8'd7, 16'd2, 16'h0002);
      push(2'b10, 8'd7, 16'd3, 16'h0003);
      @(negedge clk);
      check("in_wait", dout_busy, 0);
      #1;
      rst_n = 1'b0;
      exp_ord.delete();
      exp_resp.delete();
      #1;
      check("arst_order_valid", order_valid, 0);
      check("arst_resp_valid", resp_valid, 0);
      check("arst_in_busy", in_busy, 0);
      @(negedge clk);
      check("arst_dout_busy", dout_busy, 1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      mgr_en = 1'b1;
      repeat (6) begin
         @(negedge clk);
         check("post_rst_idle", order_valid, 0);
      end
`ifdef LINK_ORDER_ERRCNT_EN
      @(posedge clk); #1;
      check("errcnt_reset", err_count, 0);
      push(2'b00, 8'd1, 16'd1, 16'h00FF);
      push(2'b11, 8'd1, 16'd1, 16'h00FF);
      drain("drain_errcnt");
      check("errcnt", err_count, 1);
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, required completion");
      $fatal(1);
   end
endmodule

// File: doc/link_order_queue.md
LINK_ORDER_QUEUE -- requirements
Module: link_order_queue

Interface
REQ-001 Parameters SHALL be: ADDR_WIDTH, default 16, node index width; DATA_WIDTH, default 16, data width; TABLE_WIDTH, default 8, table index width; DEPTH_LOG2, default 2, order FIFO depth is 2**DEPTH_LOG2.
REQ-002 Ports SHALL be, as name, direction, width, meaning:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  host order valid.
- in_busy  out  1  queue cannot accept an order.
- in_type  in  2  00 append, 01 delete, 10 change, 11 read.
- in_table  in  TABLE_WIDTH  table index.
- in_node  in  ADDR_WIDTH  node index.
- in_data  in  DATA_WIDTH  order data.
- order_valid  out  1  order to downstream table manager.
- order_busy  in  1  manager busy.
- order_type, order_table, order_node, order_data  out  2/TABLE_WIDTH/ADDR_WIDTH/DATA_WIDTH  FIFO head fields.
- dout_valid  in  1  manager result valid.
- dout_busy  out  1  queue not ready for a result.
- dout_data  in  DATA_WIDTH  manager result.
- resp_valid  out  1  response to host.
- resp_busy  in  1  host busy.
- resp_type  out  2  type of the completed order.
- resp_data  out  DATA_WIDTH  result: read data, or 1 = ok / 0 = fatal.
REQ-003 Every handshake SHALL transfer on a cycle where valid is 1 and busy is 0.

Function
REQ-004 The FIFO SHALL hold 2**DEPTH_LOG2 orders, with a DEPTH_LOG2+1-bit count and wrapping read and write pointers.
REQ-005 in_busy SHALL equal (count == DEPTH); a push when in_busy is 1 SHALL be ignored.
REQ-006 A push and a pop in the same cycle SHALL leave count unchanged and SHALL store the pushed order.
REQ-007 The FSM SHALL have states IDLE, ISSUE, WAIT, RESP.
REQ-008 IDLE SHALL go to ISSUE when count is non-zero; otherwise it SHALL stay in IDLE.
REQ-009 order_valid SHALL be 1 exactly while in ISSUE.
REQ-010 order_* SHALL present the FIFO head and stay stable throughout ISSUE.
REQ-011 In ISSUE, an order transfer SHALL pop the FIFO, latch the type into resp_type, and go to WAIT.
REQ-012 dout_busy SHALL be 0 only in WAIT.
REQ-013 In WAIT, a result transfer SHALL register dout_data into resp_data, set resp_valid the next cycle, and go to RESP.
REQ-014 In RESP, a response transfer SHALL clear resp_valid and go to IDLE.
REQ-015 At most one order SHALL be outstanding at the manager.
REQ-016 Orders SHALL be issued in push order.
REQ-017 Minimum latency from a push into an empty idle queue to order_valid SHALL be 2 cycles.
REQ-018 Host pushes SHALL remain accepted in every FSM state while the FIFO is not full.

Reset
REQ-019 rst_n low SHALL asynchronously force state IDLE, pointers and count to 0, and the FIFO contents to don't-care.
REQ-020 Output reset values SHALL be: order_valid 0, dout_busy 1, resp_valid 0, resp_type 0, resp_data 0, in_busy 0.
REQ-021 Reset mid-operation SHALL discard all queued and outstanding orders, with no response issued.

Configuration
REQ-022 With macro LINK_ORDER_ERRCNT_EN defined, the block SHALL add output err_count (8 bits, reset 0), incremented on each result transfer of a non-read order with dout_data == 0 and saturating at 255.
REQ-023 Without LINK_ORDER_ERRCNT_EN, err_count SHALL not exist and all other behaviour SHALL be identical.

Verification
REQ-024 Push a read order (table 3, node 2) with order_busy 0 -> order_valid high 2 cycles later with order_table 3, order_node 2; dout_data 0x00AB -> resp_valid, resp_type 11, resp_data 0x00AB.
REQ-025 With DEPTH_LOG2 2, push 5 orders while order_busy is held 1 -> in_busy 1 after the 4th; the 5th is ignored; count stays 4.
REQ-026 Push 3 orders of types 00, 01, 10 back-to-back -> issued in that order, each only after the previous response transfers.
REQ-027 Hold resp_busy 1 for 10 cycles in RESP -> dout_busy stays 1, no new order_valid, and resp_data is stable.
REQ-028 Assert rst_n low while in WAIT with 2 orders queued -> next cycle order_valid 0, resp_valid 0, in_busy 0, and no order is issued after release.
REQ-029 With LINK_ORDER_ERRCNT_EN, an append with dout_data 0 followed by a read with dout_data 0 -> err_count is 1.
